// File: rtl/alu_muldiv_seq.sv
// 32x32 unsigned multiply/divide sequenced over the shared ALU's add/sub; divider built only with `define ALU_SEQ_DIV_EN.
// Latency: done 33 cycles after start (1 for div-by-zero/unsupported op); start ignored while busy, no queueing.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div0,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_div0;
  logic             r_alu_own;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_op;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;

  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic             w_unused_flags;

  assign w_c            = alu_flags[1];
  assign w_last         = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_unused_flags = ^{alu_flags[3:2], alu_flags[0]};

  // Shift-add step: carry out of the add becomes the new hi MSB.
  assign w_mul_hi = {w_c, alu_result[WIDTH-1:1]};
  assign w_mul_lo = {alu_result[0], r_lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] w_sh;
  logic             w_take;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  // hi[31] set means the shifted remainder really is >= 2^32, so it always exceeds the divisor.
  assign w_sh     = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_take   = r_hi[WIDTH-1] | w_c;
  assign w_div_hi = w_take ? alu_result : w_sh;
  assign w_div_lo = {r_lo[WIDTH-2:0], w_take};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_div0    <= 1'b0;
      r_alu_own <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= ALU_ADD;
      r_res_hi  <= '0;
      r_res_lo  <= '0;
`ifdef ALU_SEQ_DIV_EN
      r_dvsr    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div0 <= 1'b0;
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_hi   <= '0;
            if (!op_div) begin
              r_state   <= S_MUL;
              r_lo      <= opb;
              r_mcand   <= opa;
              r_alu_own <= 1'b1;
              r_alu_op  <= ALU_ADD;
              r_alu_a   <= '0;
              r_alu_b   <= opb[0] ? opa : '0;
            end
`ifdef ALU_SEQ_DIV_EN
            else if (opb != '0) begin
              r_state   <= S_DIV;
              r_lo      <= opa;
              r_dvsr    <= opb;
              r_alu_own <= 1'b1;
              r_alu_op  <= ALU_SUB;
              r_alu_a   <= {{(WIDTH-1){1'b0}}, opa[WIDTH-1]};
              r_alu_b   <= opb;
            end else begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_div0   <= 1'b1;
              r_res_hi <= opa;
              r_res_lo <= '1;
            end
`else
            else begin
              // No divider built: report the op as unsupported via div0.
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_div0   <= 1'b1;
              r_res_hi <= '0;
              r_res_lo <= '0;
            end
`endif
          end
        end

        S_MUL: begin
          r_hi  <= w_mul_hi;
          r_lo  <= w_mul_lo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_res_hi  <= w_mul_hi;
            r_res_lo  <= w_mul_lo;
            r_alu_own <= 1'b0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= ALU_ADD;
          end else begin
            r_alu_a <= w_mul_hi;
            r_alu_b <= w_mul_lo[0] ? r_mcand : '0;
          end
        end

`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          r_hi  <= w_div_hi;
          r_lo  <= w_div_lo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_res_hi  <= w_div_hi;
            r_res_lo  <= w_div_lo;
            r_alu_own <= 1'b0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= ALU_ADD;
          end else begin
            r_alu_a <= {w_div_hi[WIDTH-2:0], w_div_lo[WIDTH-1]};
            r_alu_b <= r_dvsr;
          end
        end
`endif

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy    <= 1'b0;
          r_alu_own <= 1'b0;
          r_alu_a   <= '0;
          r_alu_b   <= '0;
          r_alu_op  <= ALU_ADD;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign div0    = r_div0;
  assign res_hi  = r_res_hi;
  assign res_lo  = r_res_lo;
  assign alu_own = r_alu_own;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_op  = r_alu_op;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a combinational add/sub ALU model.
// Divide expectations follow ALU_SEQ_DIV_EN.
module tb_alu_muldiv_seq;

`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        busy, done, div0, alu_own;
  logic [31:0] res_hi, res_lo, alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic [3:0]  alu_flags;
  logic [32:0] alu_sum;

  int errors = 0;
  int checks = 0;
  int lat, own_cnt;
  bit busy_drop, done_seen;

  alu_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div),
    .opa(opa), .opb(opb), .busy(busy), .done(done),
    .res_hi(res_hi), .res_lo(res_lo), .div0(div0), .alu_own(alu_own),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // Subtract as a + ~b + 1 so carry=1 means no borrow.
  assign alu_sum    = (alu_op == 2'b01) ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1)
                                        : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_result = alu_sum[31:0];
  assign alu_flags  = {alu_sum[31], alu_sum[31:0] == 32'd0, alu_sum[32], 1'b0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, optionally pulse a conflicting start at iteration 10, then check results.
  task automatic op_check(input string tag, input logic div, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_d0);
    @(negedge clk);
    op_div = div; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; opa = $urandom; opb = $urandom;
    lat = 0; own_cnt = 0; busy_drop = 1'b0;
    while (!done && lat < 40) begin
      if (alu_own) own_cnt++;
      if (!busy) busy_drop = 1'b1;
      if (inject && lat == 10) begin
        @(negedge clk);
        start = 1'b1; op_div = ~div; opa = 32'hDEAD_BEEF; opb = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_alu_own_cycles"}, 64'(own_cnt), 64'(exp_lat));
    chk({tag, "_busy_held"}, {63'd0, busy_drop}, 64'd0);
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd1);
    chk({tag, "_res_hi"}, {32'd0, res_hi}, {32'd0, exp_hi});
    chk({tag, "_res_lo"}, {32'd0, res_lo}, {32'd0, exp_lo});
    chk({tag, "_div0"}, {63'd0, div0}, {63'd0, exp_d0});
    @(posedge clk); #1;
    chk({tag, "_idle_ctl"}, {60'd0, done, busy, alu_own, 1'b0}, 64'd0);
    chk({tag, "_idle_alu"}, {alu_a, alu_b[31:2], alu_b[1:0] | alu_op}, 64'd0);
    chk({tag, "_res_hold"}, {res_hi, res_lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {60'd0, busy, done, div0, alu_own}, 64'd0);
    chk("reset_res", {res_hi, res_lo}, 64'd0);
    chk("reset_alu", {alu_a, alu_b[31:2], alu_b[1:0] | alu_op}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    op_check("mul_zero", 1'b0, 32'h1234_5678, 32'h0, 1'b0, 32, 32'h0, 32'h0, 1'b0);
    op_check("div_by0", 1'b1, 32'h55, 32'h0, 1'b0, 0,
             DIV_EN ? 32'h55 : 32'h0, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1'b1);
    op_check("mul_7x6", 1'b0, 32'd7, 32'd6, 1'b0, 32, 32'h0, 32'd42, 1'b0);
    op_check("div_by0_again", 1'b1, 32'h55, 32'h0, 1'b0, 0,
             DIV_EN ? 32'h55 : 32'h0, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1'b1);
    op_check("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0, DIV_EN ? 32 : 0,
             DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 32'd14 : 32'd0, ~DIV_EN);
    op_check("div_hi31", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, DIV_EN ? 32 : 0,
             DIV_EN ? 32'h7FFF_FFFF : 32'h0, DIV_EN ? 32'h1 : 32'h0, ~DIV_EN);
    op_check("mul_ignore_start", 1'b0, 32'hABCD_0001, 32'h0000_0100, 1'b1, 32,
             32'h0000_00AB, 32'hCD00_0100, 1'b0);

    // Abort a long op at iteration 15 with an asynchronous reset.
    @(negedge clk);
    op_div = DIV_EN; opa = 32'd100; opb = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctl", {60'd0, busy, done, div0, alu_own}, 64'd0);
    chk("abort_res", {res_hi, res_lo}, 64'd0);
    chk("abort_alu", {alu_a, alu_b[31:2], alu_b[1:0] | alu_op}, 64'd0);
    chk("abort_no_done", {63'd0, done_seen}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("mul_after_reset", 1'b0, 32'd3, 32'd5, 1'b0, 32, 32'h0, 32'd15, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that runs 32×32 unsigned multiply and divide on the shared 32-bit ALU, using only its add and subtract operations.
- Owns the ALU operand/op bus only while busy; the core datapath mux selects the sequencer's ALU drive when alu_own=1.
- Start/done handshake toward the core control unit. One iteration per clock.

Parameters:
WIDTH, 32, operand width. Fixed by the ALU; only 32 is supported.
CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
op_div  in  1  0 = multiply, 1 = divide; sampled with start
opa  in  32  multiplicand / dividend; sampled with start
opb  in  32  multiplier / divisor; sampled with start
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse, results valid
res_hi  out  32  product[63:32] / remainder
res_lo  out  32  product[31:0] / quotient
div0  out  1  divide-by-zero flag, valid with done, held until next start
alu_own  out  1  sequencer drives the ALU (state MUL or DIV)
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_op  out  2  ALU op: 00 = add, 01 = subtract
alu_result  in  32  ALU result
alu_flags  in  4  {N,Z,C,V}; only C (bit 1) is used

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, div0, alu_own = 0.
  - res_hi, res_lo, counter, internal regs = 0.
  - alu_a, alu_b, alu_op = 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and op_div=0 → MUL. Load hi=0, lo=opb (multiplier), mcand=opa, cnt=0.
  - start=1, op_div=1, opb≠0 → DIV. Load hi=0 (remainder), lo=opa, divisor=opb, cnt=0.
  - start=1, op_div=1, opb=0 → DONE directly with res_lo=32'hFFFFFFFF, res_hi=opa, div0=1.
  - div0 is cleared on every accepted start.
- MUL, each cycle:
  - alu_op=00, alu_a=hi, alu_b = lo[0] ? mcand : 0.
  - hi ← {C, alu_result[31:1]}; lo ← {alu_result[0], lo[31:1]}.
- DIV, each cycle:
  - sh = {hi[30:0], lo[31]}; alu_op=01, alu_a=sh, alu_b=divisor.
  - take = hi[31] | C, where C=1 means no borrow. hi[31] covers the case where the true shifted value is ≥2^32.
  - take=1: hi ← alu_result, lo ← {lo[30:0],1}.
  - take=0: hi ← sh, lo ← {lo[30:0],0}.
- Iteration count:
  - cnt increments every MUL/DIV cycle.
  - At cnt=31 the last iteration completes → DONE.
  - Exactly 32 iteration cycles.
- DONE: done=1 for one cycle, busy=1, then → IDLE.
  - res_hi/res_lo are updated only on entry to DONE and hold until the next DONE.
- Latency: start sampled at edge N → done high in cycle N+33. Divide-by-zero: done in cycle N+1.
- The ALU is purely combinational: alu_result is used in the same cycle alu_a/alu_b/alu_op are driven, with no extra wait states.
- alu_own=1 only in MUL/DIV. In IDLE and DONE, alu_a/alu_b/alu_op = 0.
- start while not IDLE: ignored. No queueing, and operands are not resampled.
- Reset mid-operation: abort immediately to reset values. No done pulse.

Optional Feature:
ALU_SEQ_DIV_EN
- Defined: divide path as above.
- Undefined:
  - DIV state and divisor register are not built.
  - start with op_div=1 goes IDLE → DONE in one cycle with res_hi=res_lo=0 and div0=1 (flags unsupported op).
  - Multiply behaviour and timing are unchanged.

Test Plan:
- mul opa=32'hFFFFFFFF, opb=32'hFFFFFFFF → done at start+33; res_hi=32'hFFFFFFFE, res_lo=32'h00000001; div0=0; alu_own high for exactly 32 cycles.
- mul opa=0x12345678, opb=0 → res_hi=0, res_lo=0. mul opa=7, opb=6 → res_hi=0, res_lo=42.
- div opa=100, opb=7 → res_lo=14, res_hi=2. Div opa=32'hFFFFFFFF, opb=32'h80000000 → res_lo=1, res_hi=32'h7FFFFFFF (exercises the hi[31] take path).
- div opa=0x55, opb=0 → done at start+1, res_lo=32'hFFFFFFFF, res_hi=0x55, div0=1. Next valid div clears div0. Without ALU_SEQ_DIV_EN: res_hi=res_lo=0, div0=1.
- start pulsed at cycle 10 of a multiply with different operands → ignored; original result is returned at start+33 and busy never drops early.
- rst_n low at iteration 15 of a divide → all outputs are 0 asynchronously, no done pulse. A fresh mul 3×5 afterwards → res_lo=15.
